// File: rtl/change_dispenser.sv
// ----------------------------------------------------------------------------
// change_dispenser
//
// Turns a refund request from the vending-machine FSM into a sequence of coin
// ejections on the hopper: large coins first, then at most one small coin.
// Every ejected coin waits for a rising edge on the hopper acknowledge before
// the next coin is requested. If the hopper stays silent too long, the block
// latches a fault and stays there until reset.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset
//   change     in   1      one-cycle refund request strobe
//   rtn        in   AMT_W  refund amount in rupees (sampled with change)
//   eject_ack  in   1      hopper acknowledge for the last requested coin
//   busy       out  1      dispensing in progress (also held during fault)
//   eject_hi   out  1      one-cycle pulse: eject one COIN_HI coin
//   eject_lo   out  1      one-cycle pulse: eject one COIN_LO coin
//   done       out  1      one-cycle pulse: refund finished
//   residue    out  1      one-cycle pulse with done: amount left undispensed
//   fault      out  1      sticky acknowledge-timeout flag
// ----------------------------------------------------------------------------
module change_dispenser #(
    parameter int AMT_W       = 8,
    parameter int COIN_HI     = 10,
    parameter int COIN_LO     = 5,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change,
    input  logic [AMT_W-1:0] rtn,
    input  logic             eject_ack,
    output logic             busy,
    output logic             eject_hi,
    output logic             eject_lo,
    output logic             done,
    output logic             residue,
    output logic             fault
);

    localparam int TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [AMT_W-1:0] HI_AMT   = AMT_W'(COIN_HI);
    localparam logic [AMT_W-1:0] LO_AMT   = AMT_W'(COIN_LO);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH,
        FAULT
    } state_t;

    state_t           state,       state_nxt;
    logic [AMT_W-1:0] rem,         rem_nxt;
    logic [TMR_W-1:0] timer,       timer_nxt;
    logic             coin_is_hi,  coin_is_hi_nxt;
    logic             busy_nxt;
    logic             eject_hi_nxt;
    logic             eject_lo_nxt;
    logic             done_nxt;
    logic             residue_nxt;
    logic             fault_nxt;
    logic             ack_prev;

    logic             ack_rise;
    logic             pulse_cycle;

    // A held-high acknowledge counts only once: the hopper has to release it
    // before the next coin can be acknowledged.
    assign ack_rise = eject_ack & ~ack_prev;

    // First WAIT cycle is the one carrying the eject pulse; an acknowledge
    // arriving together with the request cannot belong to it.
    assign pulse_cycle = eject_hi | eject_lo;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rem        <= '0;
            timer      <= '0;
            coin_is_hi <= 1'b0;
            busy       <= 1'b0;
            eject_hi   <= 1'b0;
            eject_lo   <= 1'b0;
            done       <= 1'b0;
            residue    <= 1'b0;
            fault      <= 1'b0;
            ack_prev   <= 1'b0;
        end else begin
            state      <= state_nxt;
            rem        <= rem_nxt;
            timer      <= timer_nxt;
            coin_is_hi <= coin_is_hi_nxt;
            busy       <= busy_nxt;
            eject_hi   <= eject_hi_nxt;
            eject_lo   <= eject_lo_nxt;
            done       <= done_nxt;
            residue    <= residue_nxt;
            fault      <= fault_nxt;
            ack_prev   <= eject_ack;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        rem_nxt        = rem;
        timer_nxt      = timer;
        coin_is_hi_nxt = coin_is_hi;
        busy_nxt       = busy;
        eject_hi_nxt   = 1'b0;
        eject_lo_nxt   = 1'b0;
        done_nxt       = 1'b0;
        residue_nxt    = 1'b0;
        fault_nxt      = fault;

        case (state)
            IDLE: begin
                if (change) begin
                    rem_nxt   = rtn;
                    busy_nxt  = 1'b1;
                    state_nxt = ISSUE;
                end
            end

            ISSUE: begin
                timer_nxt = '0;
                if (rem >= HI_AMT) begin
                    eject_hi_nxt   = 1'b1;
                    coin_is_hi_nxt = 1'b1;
                    state_nxt      = WAIT;
                end else if (rem >= LO_AMT) begin
                    eject_lo_nxt   = 1'b1;
                    coin_is_hi_nxt = 1'b0;
                    state_nxt      = WAIT;
                end else begin
                    state_nxt = FINISH;
                end
            end

            WAIT: begin
                if (!pulse_cycle && ack_rise) begin
                    // rem covered this coin when it was issued, so no underflow
                    rem_nxt   = rem - (coin_is_hi ? HI_AMT : LO_AMT);
                    state_nxt = ISSUE;
                end else if (timer == TMR_LAST) begin
                    fault_nxt = 1'b1;
                    state_nxt = FAULT;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end

            FINISH: begin
                done_nxt    = 1'b1;
                residue_nxt = (rem != '0);
                busy_nxt    = 1'b0;
                state_nxt   = IDLE;
            end

            FAULT: begin
                fault_nxt = 1'b1;
                busy_nxt  = 1'b1;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

    localparam int AMT_W = 8;
    localparam int TMO   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             change;
    logic [AMT_W-1:0] rtn;
    logic             eject_ack;
    logic             busy, eject_hi, eject_lo, done, residue, fault;

    int tests_run    = 0;
    int tests_failed = 0;

    int hi_cnt   = 0;
    int lo_cnt   = 0;
    int both_cnt = 0;

    change_dispenser #(
        .AMT_W      (AMT_W),
        .COIN_HI    (10),
        .COIN_LO    (5),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .change   (change),
        .rtn      (rtn),
        .eject_ack(eject_ack),
        .busy     (busy),
        .eject_hi (eject_hi),
        .eject_lo (eject_lo),
        .done     (done),
        .residue  (residue),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping, sampled mid-cycle
    always @(negedge clk) begin
        if (eject_hi)             hi_cnt   <= hi_cnt + 1;
        if (eject_lo)             lo_cnt   <= lo_cnt + 1;
        if (eject_hi && eject_lo) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe change for one cycle; returns in cycle N+1
    task automatic start(input logic [AMT_W-1:0] amt);
        change = 1'b1;
        rtn    = amt;
        tick();
        change = 1'b0;
        rtn    = 8'd99;
    endtask

    // Acknowledge the coin whose pulse is visible now (one cycle later, one cycle wide)
    task automatic ack_coin();
        tick();
        eject_ack = 1'b1;
        tick();
        eject_ack = 1'b0;
    endtask

    // Wait for next eject or done: ev 1=hi, 2=lo, 3=done, 0=timeout
    task automatic next_event(output int ev, output int n);
        ev = 0;
        n  = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (eject_hi)      begin ev = 1; break; end
            else if (eject_lo) begin ev = 2; break; end
            else if (done)     begin ev = 3; break; end
        end
    endtask

    int ev, n, h0, l0;

    initial begin
        rst       = 1'b1;
        change    = 1'b0;
        rtn       = '0;
        eject_ack = 1'b0;
        tick();
        tick();
        check("rst_busy",  busy,     0);
        check("rst_ehi",   eject_hi, 0);
        check("rst_elo",   eject_lo, 0);
        check("rst_done",  done,     0);
        check("rst_res",   residue,  0);
        check("rst_fault", fault,    0);
        rst = 1'b0;
        tick();

        // rtn=5: single small coin, first pulse in N+2
        h0 = hi_cnt; l0 = lo_cnt;
        start(8'd5);
        check("r5_busy_n1", busy, 1);
        next_event(ev, n);
        check("r5_ev1", ev, 2);
        check("r5_lat", n, 1);
        ack_coin();
        next_event(ev, n);
        check("r5_done", ev, 3);
        check("r5_done_lat", n, 2);
        check("r5_res", residue, 0);
        check("r5_busy", busy, 0);
        check("r5_nhi", hi_cnt - h0, 0);
        check("r5_nlo", lo_cnt - l0, 1);
        tick();

        // rtn=0: no coins, done at N+3, busy N+1..N+2
        h0 = hi_cnt; l0 = lo_cnt;
        start(8'd0);
        check("r0_busy_n1", busy, 1);
        tick();
        check("r0_busy_n2", busy, 1);
        check("r0_nodone_n2", done, 0);
        tick();
        check("r0_done_n3", done, 1);
        check("r0_res", residue, 0);
        check("r0_busy_n3", busy, 0);
        tick();
        check("r0_done_1cyc", done, 0);
        check("r0_noeject", (hi_cnt - h0) + (lo_cnt - l0), 0);

        // rtn=25: hi, hi, lo, done
        start(8'd25);
        next_event(ev, n); check("r25_ev1", ev, 1); check("r25_lat1", n, 1);
        ack_coin();
        next_event(ev, n); check("r25_ev2", ev, 1); check("r25_lat2", n, 1);
        ack_coin();
        next_event(ev, n); check("r25_ev3", ev, 2); check("r25_lat3", n, 1);
        ack_coin();
        next_event(ev, n); check("r25_done", ev, 3);
        check("r25_res", residue, 0);
        tick();

        // rtn=17: hi, lo, done with residue
        start(8'd17);
        next_event(ev, n); check("r17_ev1", ev, 1);
        ack_coin();
        next_event(ev, n); check("r17_ev2", ev, 2);
        ack_coin();
        next_event(ev, n); check("r17_done", ev, 3);
        check("r17_res", residue, 1);
        tick();
        check("r17_res_1cyc", residue, 0);

        // Ack coincident with the pulse is ignored
        start(8'd10);
        next_event(ev, n); check("coin_ev1", ev, 1);
        eject_ack = 1'b1;
        tick();
        eject_ack = 1'b0;
        tick(); tick(); tick();
        check("coin_still_busy", busy, 1);
        check("coin_no_done", done, 0);
        eject_ack = 1'b1;
        tick();
        eject_ack = 1'b0;
        next_event(ev, n); check("coin_done", ev, 3);
        tick();

        // Held-high ack counts once
        start(8'd20);
        next_event(ev, n); check("hold_ev1", ev, 1);
        tick();
        eject_ack = 1'b1;
        next_event(ev, n); check("hold_ev2", ev, 1);
        for (int i = 0; i < 5; i++) tick();
        check("hold_no_done", done, 0);
        check("hold_busy", busy, 1);
        eject_ack = 1'b0;
        tick();
        eject_ack = 1'b1;
        tick();
        eject_ack = 1'b0;
        next_event(ev, n); check("hold_done", ev, 3);
        tick();

        // Second change while busy is ignored
        h0 = hi_cnt; l0 = lo_cnt;
        start(8'd10);
        change = 1'b1;
        rtn    = 8'd15;
        tick();
        change = 1'b0;
        check("dbl_pulse", eject_hi, 1);
        ack_coin();
        next_event(ev, n); check("dbl_done", ev, 3);
        check("dbl_res", residue, 0);
        check("dbl_nhi", hi_cnt - h0, 1);
        check("dbl_nlo", lo_cnt - l0, 0);
        tick();

        // Ack timeout -> sticky fault
        start(8'd10);
        next_event(ev, n); check("tmo_ev1", ev, 1);
        for (int i = 0; i < TMO - 1; i++) tick();
        check("tmo_fault_early", fault, 0);
        tick();
        check("tmo_fault", fault, 1);
        check("tmo_busy", busy, 1);
        h0 = hi_cnt; l0 = lo_cnt;
        start(8'd5);
        for (int i = 0; i < 6; i++) tick();
        check("tmo_ignored", (hi_cnt - h0) + (lo_cnt - l0), 0);
        check("tmo_fault_held", fault, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("tmo_rst_fault", fault, 0);
        check("tmo_rst_busy", busy, 0);
        tick();

        // Reset in WAIT aborts the refund
        start(8'd25);
        next_event(ev, n); check("abrt_ev1", ev, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abrt_busy", busy, 0);
        check("abrt_ehi", eject_hi, 0);
        check("abrt_done", done, 0);
        h0 = hi_cnt; l0 = lo_cnt;
        eject_ack = 1'b1;
        tick();
        eject_ack = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("abrt_noeject", (hi_cnt - h0) + (lo_cnt - l0), 0);
        check("abrt_idle", busy, 0);

        check("never_both", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
